alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mdu_iter.sv | 106 ++++++++++
 rtl/alu_muldiv.sv | 156 +++++++++++++++
 tb/tb_alu_muldiv.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / multiply-divide block: default width,
// opcode encoding and controller states.
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  typedef enum logic [3:0] {
    OP_ADDU  = 4'd0,
    OP_SUBU  = 4'd1,
    OP_OR    = 4'd2,
    OP_SLT   = 4'd3,
    OP_ADD   = 4'd4,
    OP_LUI   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_AND   = 4'd7,
    OP_MULTU = 4'd8,
    OP_MULT  = 4'd9,
    OP_DIVU  = 4'd10,
    OP_DIV   = 4'd11,
    OP_MFHI  = 4'd12,
    OP_MFLO  = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative 1-bit-per-cycle engine: shift-add multiplier and restoring divider
// on operand magnitudes, with sign fix-up applied to the final step's result.
module alu_mdu_iter
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_div,
  input  logic         is_signed,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int unsigned CW = $clog2(W + 1);

  logic          r_busy;
  logic          r_div;
  logic          r_neg_q;
  logic          r_neg_r;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;

  logic          w_a_neg;
  logic          w_b_neg;
  logic [W-1:0]  w_abs_a;
  logic [W-1:0]  w_abs_b;
  logic [W:0]    w_sum;
  logic [W:0]    w_rs;
  logic [W:0]    w_diff;
  logic          w_ge;
  logic [W-1:0]  w_hi_n;
  logic [W-1:0]  w_lo_n;
  logic [2*W-1:0] w_prod;

  assign w_a_neg = is_signed & a[W-1];
  assign w_b_neg = is_signed & b[W-1];
  assign w_abs_a = w_a_neg ? -a : a;
  assign w_abs_b = w_b_neg ? -b : b;

  assign done = r_busy && (r_cnt == CW'(W - 1));

  // Results are taken from the next-step values so the W-th step and the
  // sign fix-up land on the same edge.
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_x} : '0);
    w_rs   = {r_hi, r_lo[W-1]};
    w_diff = w_rs - {1'b0, r_x};
    w_ge   = (w_rs >= {1'b0, r_x});
    if (r_div) begin
      w_hi_n = w_ge ? w_diff[W-1:0] : w_rs[W-1:0];
      w_lo_n = {r_lo[W-2:0], w_ge};
    end else begin
      w_hi_n = w_sum[W:1];
      w_lo_n = {w_sum[0], r_lo[W-1:1]};
    end
    w_prod = {w_hi_n, w_lo_n};
    if (r_neg_q) w_prod = -w_prod;
    if (r_div) begin
      hi = r_neg_r ? -w_hi_n : w_hi_n;
      lo = r_neg_q ? -w_lo_n : w_lo_n;
    end else begin
      hi = w_prod[2*W-1:W];
      lo = w_prod[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
      r_x     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (start) begin
      r_busy  <= 1'b1;
      r_div   <= is_div;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_cnt   <= '0;
      r_x     <= w_abs_b;
      r_hi    <= '0;
      r_lo    <= w_abs_a;
    end else if (r_busy) begin
      r_hi <= w_hi_n;
      r_lo <= w_lo_n;
      if (done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// ALU with single-cycle logic/arithmetic ops and a multi-cycle multiply/divide
// unit writing HI/LO; results are registered and presented with out_valid.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned W   = ALU_W,
  parameter int unsigned OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic [15:0]    imm16,
  output logic           out_valid,
  output logic [W-1:0]   out_c,
  output logic           flag_zero,
  output logic           flag_overflow,
  output logic           flag_div0
);

  alu_state_e   r_state;
  logic         r_out_valid;
  logic [W-1:0] r_out_c;
  logic         r_flag_zero;
  logic         r_flag_ovf;
  logic         r_flag_div0;
  logic [W-1:0] r_hi;
  logic [W-1:0] r_lo;
  logic [W-1:0] r_a;
  logic         r_div0;
  logic         r_ovf;

  alu_op_e      w_op;
  logic         w_accept;
  logic         w_is_mdu;
  logic         w_is_div;
  logic         w_is_signed;
  logic         w_start;
  logic [W-1:0] w_sum;
  logic [W-1:0] w_res;
  logic         w_ovf;
  logic         w_done;
  logic [W-1:0] w_hi;
  logic [W-1:0] w_lo;
  logic [W-1:0] w_new_hi;
  logic [W-1:0] w_new_lo;

  assign w_op        = alu_op_e'(4'(op));
  assign in_ready    = (r_state == ST_IDLE);
  assign w_accept    = in_valid && in_ready;
  assign w_is_mdu    = (w_op == OP_MULTU) || (w_op == OP_MULT) ||
                       (w_op == OP_DIVU)  || (w_op == OP_DIV);
  assign w_is_div    = (w_op == OP_DIVU) || (w_op == OP_DIV);
  assign w_is_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
  assign w_start     = w_accept && w_is_mdu;
  assign w_sum       = in_a + in_b;

  assign out_valid     = r_out_valid;
  assign out_c         = r_out_c;
  assign flag_zero     = r_flag_zero;
  assign flag_overflow = r_flag_ovf;
  assign flag_div0     = r_flag_div0;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (w_op)
      OP_ADDU: w_res = w_sum;
      OP_SUBU: w_res = in_a - in_b;
      OP_OR:   w_res = in_a | in_b;
      OP_SLT:  w_res = {{(W-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (in_a[W-1] == in_b[W-1]) && (w_sum[W-1] != in_a[W-1]);
      end
      OP_LUI:  w_res = {imm16, {(W-16){1'b0}}};
      OP_SLTU: w_res = {{(W-1){1'b0}}, (in_a < in_b)};
      OP_AND:  w_res = in_a & in_b;
      OP_MFHI: w_res = r_hi;
      OP_MFLO: w_res = r_lo;
      default: w_res = '0;
    endcase
  end

  alu_mdu_iter #(.W(W)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (w_start),
    .is_div    (w_is_div),
    .is_signed (w_is_signed),
    .a         (in_a),
    .b         (in_b),
    .done      (w_done),
    .hi        (w_hi),
    .lo        (w_lo)
  );

  // Divide-by-zero bypasses the engine result with a fixed pattern.
  assign w_new_hi = r_div0 ? r_a : w_hi;
  assign w_new_lo = r_div0 ? '1  : w_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_c     <= '0;
      r_flag_zero <= 1'b0;
      r_flag_ovf  <= 1'b0;
      r_flag_div0 <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_a         <= '0;
      r_div0      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_mdu) begin
              r_state <= w_is_div ? ST_DIV : ST_MUL;
              r_a     <= in_a;
              r_div0  <= w_is_div && (in_b == '0);
              r_ovf   <= (w_op == OP_DIV) && (in_a == {1'b1, {(W-1){1'b0}}}) &&
                         (in_b == '1);
            end else begin
              r_out_valid <= 1'b1;
              r_out_c     <= w_res;
              r_flag_zero <= (w_res == '0);
              r_flag_ovf  <= w_ovf;
              r_flag_div0 <= 1'b0;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_done) begin
            r_state     <= ST_DONE;
            r_hi        <= w_new_hi;
            r_lo        <= w_new_lo;
            r_out_valid <= 1'b1;
            r_out_c     <= w_new_lo;
            r_flag_zero <= (w_new_lo == '0);
            r_flag_ovf  <= r_ovf;
            r_flag_div0 <= r_div0;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: an arithmetic reference model queues the
// expected result and arrival cycle; a monitor compares on each out_valid.
module tb_alu_muldiv;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [15:0] imm16;
  logic        out_valid;
  logic [31:0] out_c;
  logic        flag_zero;
  logic        flag_overflow;
  logic        flag_div0;

  alu_muldiv #(.W(W), .OPW(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op            (op),
    .in_a          (in_a),
    .in_b          (in_b),
    .imm16         (imm16),
    .out_valid     (out_valid),
    .out_c         (out_c),
    .flag_zero     (flag_zero),
    .flag_overflow (flag_overflow),
    .flag_div0     (flag_div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c;
    logic        z;
    logic        ov;
    logic        d0;
    int          cyc;
  } exp_t;

  exp_t        scb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  task automatic push_expect(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [15:0] imm, input int acc);
    exp_t        e;
    longint      sa;
    longint      sbv;
    longint      q;
    longint      r;
    logic [63:0] up;
    e.ov  = 1'b0;
    e.d0  = 1'b0;
    e.cyc = acc + 1;
    e.c   = '0;
    case (o)
      4'd0: e.c = a + b;
      4'd1: e.c = a - b;
      4'd2: e.c = a | b;
      4'd3: e.c = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: begin
        sa   = longint'($signed(a)) + longint'($signed(b));
        e.c  = sa[31:0];
        e.ov = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
      end
      4'd5: e.c = {imm, 16'h0000};
      4'd6: e.c = (a < b) ? 32'd1 : 32'd0;
      4'd7: e.c = a & b;
      4'd8: begin
        up = 64'(a) * 64'(b);
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      4'd9: begin
        sa = longint'($signed(a)) * longint'($signed(b));
        m_hi = sa[63:32];
        m_lo = sa[31:0];
      end
      4'd10: begin
        if (b == 0) begin m_lo = 32'hFFFFFFFF; m_hi = a; e.d0 = 1'b1; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      4'd11: begin
        if (b == 0) begin
          m_lo = 32'hFFFFFFFF; m_hi = a; e.d0 = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          m_lo = a; m_hi = 32'h0; e.ov = 1'b1;
        end else begin
          sa  = longint'($signed(a));
          sbv = longint'($signed(b));
          q   = sa / sbv;
          r   = sa % sbv;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      4'd12: e.c = m_hi;
      4'd13: e.c = m_lo;
      default: e.c = '0;
    endcase
    if (o >= 4'd8 && o <= 4'd11) begin
      e.c   = m_lo;
      e.cyc = acc + W + 1;
    end
    e.z = (e.c == 0);
    scb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (scb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = scb.pop_front();
        chk("out_c", out_c, e.c);
        chk("flag_zero", flag_zero, e.z);
        chk("flag_overflow", flag_overflow, e.ov);
        chk("flag_div0", flag_div0, e.d0);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] imm);
    int n = 0;
    @(negedge clk);
    op = o; in_a = a; in_b = b; imm16 = imm; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      push_expect(o, a, b, imm, cyc);
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (o < 4'd8 || o > 4'd11) chk("ready_after_single", in_ready, 1);
    end
  endtask

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] corners [5];
    corners[0] = 32'h00000000;
    corners[1] = 32'h00000001;
    corners[2] = 32'hFFFFFFFF;
    corners[3] = 32'h80000000;
    corners[4] = 32'h7FFFFFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b1; in_valid = 1'b0; op = '0; in_a = '0; in_b = '0; imm16 = '0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_c", out_c, 0);
    chk("rst_flags", {flag_zero, flag_overflow, flag_div0}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(4'd4, 32'h7FFFFFFF, 32'h00000001, 16'h0);
    issue(4'd0, 32'h7FFFFFFF, 32'h00000001, 16'h0);
    issue(4'd1, 32'd5, 32'd5, 16'h0);
    issue(4'd3, 32'hFFFFFFFF, 32'd1, 16'h0);
    issue(4'd6, 32'hFFFFFFFF, 32'd1, 16'h0);
    issue(4'd5, 32'h0, 32'h0, 16'hABCD);
    issue(4'd14, 32'h1234, 32'h5678, 16'h0);

    issue(4'd9, 32'hFFFFFFFD, 32'd7, 16'h0);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mult_ready_low_cycles", n, W + 1);
    issue(4'd12, 32'h0, 32'h0, 16'h0);
    issue(4'd13, 32'h0, 32'h0, 16'h0);

    issue(4'd11, 32'hFFFFFFF9, 32'd2, 16'h0);
    issue(4'd12, 32'h0, 32'h0, 16'h0);
    issue(4'd10, 32'd9, 32'd0, 16'h0);
    issue(4'd12, 32'h0, 32'h0, 16'h0);
    issue(4'd11, 32'h80000000, 32'hFFFFFFFF, 16'h0);
    issue(4'd12, 32'h0, 32'h0, 16'h0);

    // ADDU held valid while DIVU is busy: must be taken exactly once.
    issue(4'd10, 32'd100, 32'd7, 16'h0);
    issue(4'd0, 32'd11, 32'd22, 16'h0);

    // Abort MULTU with reset ten cycles in.
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    op = 4'd8; in_a = 32'h12345678; in_b = 32'h9ABCDEF0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("busy_before_rst", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_c", out_c, 0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    issue(4'd13, 32'h0, 32'h0, 16'h0);
    issue(4'd12, 32'h0, 32'h0, 16'h0);

    for (int i = 0; i < 150; i++) begin
      ra = rnd_opnd();
      rb = ($urandom_range(0, 9) == 0) ? 32'h0 : rnd_opnd();
      issue(4'($urandom_range(0, 15)), ra, rb, 16'($urandom()));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end

    n = 0;
    while (scb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("scoreboard_drain", scb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
